// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the pipeline datapath and the
// hazard_stall_unit.
//   master: pipeline side; drives ID/EX hazard information, branch
//           resolution and memory wait, and receives the stall/flush
//           controls plus the event counters.
//   slave : hazard_stall_unit side.
// Signals:
//   IFIDrs1/IFIDrs2/IFID_uses_rs2 : source registers of the ID instruction
//   IDEXrd/IDEX_memread           : destination and load flag of EX instr
//   branch_taken                  : EX resolved a taken branch/jump
//   mem_busy                      : data memory not ready for MEM access
//   pc_write/IFID_write           : PC and IF/ID load enables
//   IFID_flush/IDEX_flush         : load NOP / bubble into IF/ID, ID/EX
//   pipe_hold                     : freeze ID/EX, EX/MEM, MEM/WB
//   load_use_cnt/redirect_cnt/mem_wait_cnt : saturating event counters
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFIDrs1;
  logic [4:0]       IFIDrs2;
  logic             IFID_uses_rs2;
  logic [4:0]       IDEXrd;
  logic             IDEX_memread;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             IFID_write;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  modport master (
    output IFIDrs1, IFIDrs2, IFID_uses_rs2, IDEXrd, IDEX_memread,
           branch_taken, mem_busy,
    input  pc_write, IFID_write, IFID_flush, IDEX_flush, pipe_hold,
           load_use_cnt, redirect_cnt, mem_wait_cnt
  );

  modport slave (
    input  IFIDrs1, IFIDrs2, IFID_uses_rs2, IDEXrd, IDEX_memread,
           branch_taken, mem_busy,
    output pc_write, IFID_write, IFID_flush, IDEX_flush, pipe_hold,
           load_use_cnt, redirect_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage stall/flush controller for the 5-stage RV32
// pipeline. Resolves the hazards forwarding cannot: load-use, taken
// branch/jump redirect and data-memory wait states. Priority per cycle:
// mem_busy, then branch_taken, then load-use.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   hz    : hazard_stall_unit_if.slave bundle (see interface header)
// Parameters:
//   CNT_W           : width of each saturating event counter
//   REDIRECT_CYCLES : cycles IF/ID is flushed after a taken redirect (1..7)
module hazard_stall_unit #(
  parameter int          CNT_W           = 16,
  parameter int unsigned REDIRECT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT
  } state_t;

  localparam logic [2:0] REDIR_RELOAD = 3'(REDIRECT_CYCLES - 1);

  state_t           state;
  logic [2:0]       redir_left;
  logic [CNT_W-1:0] load_use_q;
  logic [CNT_W-1:0] redirect_q;
  logic [CNT_W-1:0] mem_wait_q;

  logic lu;
  logic ev_busy;
  logic ev_redirect;
  logic ev_flush_only;
  logic ev_lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // MEM_WAIT with mem_busy low decodes exactly like RUN, so only REDIRECT
  // needs distinguishing in the event decode.
  always_comb begin
    lu = hz.IDEX_memread && (hz.IDEXrd != 5'd0) &&
         ((hz.IDEXrd == hz.IFIDrs1) ||
          (hz.IFID_uses_rs2 && (hz.IDEXrd == hz.IFIDrs2)));
    ev_busy       = hz.mem_busy;
    ev_redirect   = !hz.mem_busy && hz.branch_taken;
    ev_flush_only = !hz.mem_busy && !hz.branch_taken && (state == REDIRECT);
    ev_lu         = !hz.mem_busy && !hz.branch_taken && (state != REDIRECT) && lu;
  end

  always_comb begin
    hz.pc_write     = !(ev_busy || ev_lu);
    hz.IFID_write   = !(ev_busy || ev_lu);
    hz.IFID_flush   = ev_redirect || ev_flush_only;
    hz.IDEX_flush   = ev_redirect || ev_lu;
    hz.pipe_hold    = ev_busy;
    hz.load_use_cnt = load_use_q;
    hz.redirect_cnt = redirect_q;
    hz.mem_wait_cnt = mem_wait_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      redir_left <= '0;
      load_use_q <= '0;
      redirect_q <= '0;
      mem_wait_q <= '0;
    end else if (ev_busy) begin
      // A freeze inside REDIRECT keeps the remaining flush count intact.
      mem_wait_q <= sat_inc(mem_wait_q);
      if (state != REDIRECT) state <= MEM_WAIT;
    end else if (ev_redirect) begin
      redirect_q <= sat_inc(redirect_q);
      if (REDIRECT_CYCLES > 1) begin
        state      <= REDIRECT;
        redir_left <= REDIR_RELOAD;
      end else begin
        state <= RUN;
      end
    end else if (ev_flush_only) begin
      if (redir_left <= 3'd1) state <= RUN;
      else                    redir_left <= redir_left - 3'd1;
    end else begin
      state <= RUN;
      if (ev_lu) load_use_q <= sat_inc(load_use_q);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed scenarios followed by random
// stimulus. Expected per-cycle controls and counter values are computed by
// a pending-flush-count reference model and queued; a negedge monitor pops
// and compares.
module tb_hazard_stall_unit;

  localparam int CNT_W   = 5;
  localparam int RC      = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_stall_unit #(
    .CNT_W           (CNT_W),
    .REDIRECT_CYCLES (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0] ctl;  // {pc_write, IFID_write, IFID_flush, IDEX_flush, pipe_hold}
    int         lu;
    int         rd;
    int         mw;
  } exp_t;

  exp_t sb[$];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  bit m_valid = 1'b0;
  int m_left  = 0;   // flush-only cycles still owed after a redirect
  int m_lu    = 0;
  int m_rd    = 0;
  int m_mw    = 0;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic step(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit u2, input bit [4:0] rd, input bit mr,
                      input bit br, input bit mb);
    exp_t e;
    bit   hazard;
    reset            = rst;
    hz.IFIDrs1       = rs1;
    hz.IFIDrs2       = rs2;
    hz.IFID_uses_rs2 = u2;
    hz.IDEXrd        = rd;
    hz.IDEX_memread  = mr;
    hz.branch_taken  = br;
    hz.mem_busy      = mb;
    hazard = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    if (m_valid) begin
      e.lu = m_lu;
      e.rd = m_rd;
      e.mw = m_mw;
      if (mb)              e.ctl = 5'b00001;
      else if (br)         e.ctl = 5'b11110;
      else if (m_left > 0) e.ctl = 5'b11100;
      else if (hazard)     e.ctl = 5'b00010;
      else                 e.ctl = 5'b11000;
      sb.push_back(e);
    end
    if (rst) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_lu    = 0;
      m_rd    = 0;
      m_mw    = 0;
    end else if (m_valid) begin
      if (mb) m_mw = sat(m_mw);
      else if (br) begin
        m_rd   = sat(m_rd);
        m_left = RC - 1;
      end else if (m_left > 0) m_left = m_left - 1;
      else if (hazard) m_lu = sat(m_lu);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every cycle the model produced an expectation for.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {hz.pc_write, hz.IFID_write, hz.IFID_flush, hz.IDEX_flush, hz.pipe_hold};
      vectors++;
      if (act !== e.ctl) begin
        miscompares++;
        $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
      end
      vectors++;
      if (hz.load_use_cnt !== CNT_W'(e.lu)) begin
        miscompares++;
        $display("FAIL load_use_cnt @%0t: got %0d expected %0d", $time, hz.load_use_cnt, e.lu);
      end
      vectors++;
      if (hz.redirect_cnt !== CNT_W'(e.rd)) begin
        miscompares++;
        $display("FAIL redirect_cnt @%0t: got %0d expected %0d", $time, hz.redirect_cnt, e.rd);
      end
      vectors++;
      if (hz.mem_wait_cnt !== CNT_W'(e.mw)) begin
        miscompares++;
        $display("FAIL mem_wait_cnt @%0t: got %0d expected %0d", $time, hz.mem_wait_cnt, e.mw);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset
    step(1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Load-use on rs1: one stall cycle, then bubble clears it
    step(0, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step(0, 5'd5, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    // Load-use on rs2
    step(0, 5'd3, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    idle(1);

    // No stall: x0 destination, and rs2 unused
    step(0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    step(0, 5'd3, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Redirect pulse: three IF/ID flush cycles, ID/EX flushed only first
    step(0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    step(0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(3);

    // mem_busy for 4 cycles over branch and lu, then redirect wins
    for (int i = 0; i < 4; i++) step(0, 5'd4, 5'd1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    step(0, 5'd4, 5'd1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    idle(3);

    // mem_busy inside REDIRECT preserves the remaining flush count
    step(0, 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    step(0, 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    step(0, 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    // New redirect while still in REDIRECT reloads the count
    step(0, 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Saturation of load_use_cnt
    for (int i = 0; i < CNT_MAX + 4; i++) step(0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Reset during REDIRECT with two cycles remaining
    step(0, 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    step(1, 5'd1, 5'd2, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 4) == 0));
    end
    idle(2);

    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage RV32 pipeline.
- It is the ID-stage counterpart of the EX-stage forwarding logic. It handles every hazard that forwarding cannot resolve: load-use, taken branch/jump redirect, and data-memory wait states.
- It drives the write-enables and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- It keeps saturating event counters for performance debug.

Parameters:
- CNT_W, 16, width of each saturating event counter.
- REDIRECT_CYCLES, 1, cycles IF/ID is flushed after a taken redirect (1..7); values above 1 support multi-cycle instruction fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- IFIDrs1  in  5  rs1 of instruction in ID.
- IFIDrs2  in  5  rs2 of instruction in ID.
- IFID_uses_rs2  in  1  ID instruction reads rs2 (R/S/B type).
- IDEXrd  in  5  rd of instruction in EX.
- IDEX_memread  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_busy  in  1  data memory not ready for the MEM-stage access.
- pc_write  out  1  PC register load enable.
- IFID_write  out  1  IF/ID load enable.
- IFID_flush  out  1  IF/ID loads a NOP.
- IDEX_flush  out  1  ID/EX loads a bubble (all controls 0).
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- load_use_cnt  out  CNT_W  load-use stalls taken.
- redirect_cnt  out  CNT_W  redirects taken.
- mem_wait_cnt  out  CNT_W  cycles frozen on mem_busy.

Behaviour:
- FSM states: RUN, MEM_WAIT, REDIRECT. State is registered; control outputs are combinational from state and current inputs.
- Reset: state=RUN, redirect counter=0, all event counters=0.
- Control outputs in RUN with no hazard: pc_write=1, IFID_write=1, flushes=0, pipe_hold=0.
- Load-use hazard (lu) is asserted when all of the following hold:
  - IDEX_memread=1;
  - IDEXrd!=0;
  - IDEXrd==IFIDrs1, or IFID_uses_rs2 && IDEXrd==IFIDrs2.
- Priority within one cycle, highest first: mem_busy, then branch_taken, then lu.
- RUN with mem_busy=1:
  - pc_write=0, IFID_write=0, pipe_hold=1, no flushes.
  - Next state MEM_WAIT.
  - mem_wait_cnt increments.
  - A coincident branch_taken or lu is ignored this cycle; it is re-evaluated once the pipeline unfreezes, because the stage contents are unchanged.
- MEM_WAIT:
  - Same outputs as RUN with mem_busy=1 while mem_busy=1; mem_wait_cnt increments every such cycle.
  - When mem_busy=0, the cycle is evaluated exactly as RUN (same cycle, no extra bubble) and the next state follows the RUN rules.
- RUN with branch_taken=1 and mem_busy=0:
  - IFID_flush=1, IDEX_flush=1, pc_write=1 (the PC loads the target), IFID_write=1.
  - redirect_cnt increments.
  - If REDIRECT_CYCLES>1: next state REDIRECT, remaining count = REDIRECT_CYCLES-1. Otherwise stay in RUN.
  - lu is suppressed because the ID instruction is being killed.
- REDIRECT:
  - Outputs: IFID_flush=1, IDEX_flush=0, pc_write=1. lu is suppressed.
  - Remaining count decrements each non-busy cycle; return to RUN when it reaches 1.
  - mem_busy=1 in REDIRECT freezes the pipeline as in MEM_WAIT and preserves the remaining count. The state stays REDIRECT, and mem_wait_cnt increments.
  - branch_taken=1 in REDIRECT is a new redirect: flush both stages, reload the count, and increment redirect_cnt.
- RUN with lu=1 and no higher-priority event:
  - pc_write=0, IFID_write=0, IDEX_flush=1, pipe_hold=0.
  - Exactly one bubble is inserted. load_use_cnt increments once per stalled cycle.
  - The next cycle, IDEX_memread=0 (bubble), so the hazard clears naturally; the forwarding path then supplies the load data from MEM/WB.
- Event counters saturate at all-ones and never wrap.
- x0 as a destination never causes a stall.
- reset asserted mid-stall or mid-redirect returns to RUN on the next edge with counters cleared. Outputs follow RUN rules in the first post-reset cycle.

Test Plan:
- lw x5 in EX (IDEXrd=5, IDEX_memread=1), ID reads IFIDrs1=5 → pc_write=0, IFID_write=0, IDEX_flush=1 for exactly 1 cycle; load_use_cnt=1.
- Same as above but IDEXrd=0 or IFID_uses_rs2=0 with IFIDrs2=5, IFIDrs1=3 → no stall, all counters unchanged.
- branch_taken=1 pulse, REDIRECT_CYCLES=3 → IFID_flush=1 for 3 consecutive cycles, IDEX_flush=1 only in the first; redirect_cnt=1.
- mem_busy=1 for 4 cycles coincident with branch_taken=1 and lu → pipe_hold=1 and pc_write=0 for 4 cycles; mem_wait_cnt=4; the redirect is then taken in the 5th cycle and the lu stall is not taken.
- Force load_use_cnt to 0xFFFE via 3 further stalls → value holds at 0xFFFF.
- Assert reset during REDIRECT with 2 cycles remaining → next cycle state RUN, IFID_flush=0, all counters 0.
